// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stages: default component width, complex
// packing widths and the SDF stage state encoding.
package fft_pkg;
    localparam int NBITS_DEF = 10;
    localparam int CPLX_W_DEF = 2 * NBITS_DEF;
    localparam int RE_LSB_DEF = NBITS_DEF;
    localparam int IM_LSB_DEF = 0;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_BFLY  = 2'd1,
        ST_DRAIN = 2'd2
    } sdf_state_t;
endpackage

// File: rtl/ibfj_core.sv
// Combinational inverse radix-2 butterfly: scaled sum/difference plus the
// unity / +j twiddle on the difference path.
module ibfj_core
    import fft_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic [2*NBITS-1:0] a,
    input  logic [2*NBITS-1:0] b,
    input  logic               twd,
    output logic [2*NBITS-1:0] up,
    output logic [2*NBITS-1:0] down
);
    // Floor-divide an NBITS+1 result by two; the top bits always fit NBITS.
    function automatic logic [NBITS-1:0] half(input logic [NBITS:0] x);
        return x[NBITS:1];
    endfunction

    logic [NBITS:0] ar, ai, br, bi;
    logic [NBITS:0] sum_r, sum_i, dif_r, dif_i, neg_i;

    assign ar = {a[2*NBITS-1], a[2*NBITS-1:NBITS]};
    assign ai = {a[NBITS-1], a[NBITS-1:0]};
    assign br = {b[2*NBITS-1], b[2*NBITS-1:NBITS]};
    assign bi = {b[NBITS-1], b[NBITS-1:0]};

    assign sum_r = ar + br;
    assign sum_i = ai + bi;
    assign dif_r = ar - br;
    assign dif_i = ai - bi;
    assign neg_i = -dif_i;

    assign up   = {half(sum_r), half(sum_i)};
    assign down = twd ? {half(dif_r), half(dif_i)} : {half(neg_i), half(dif_r)};
endmodule

// File: rtl/ibfj_sdf_stage.sv
// Radix-2 single-path delay-feedback inverse butterfly stage: first half of
// each block fills the delay line, second half emits up and stores down.
module ibfj_sdf_stage
    import fft_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NBITS-1:0] in_data,
    input  logic               twd,
    input  logic               flush,
    output logic               out_valid,
    output logic [2*NBITS-1:0] out_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sdf_state_t         state;
    logic [AW-1:0]      cnt;
    logic               pending;
    logic [2*NBITS-1:0] mem [DEPTH];
    logic [2*NBITS-1:0] rd, up, down;
    logic               flush_go, accept, last;

    assign rd       = mem[cnt];
    assign last     = (cnt == AW'(DEPTH - 1));
    assign flush_go = (state == ST_FILL) && flush && pending && (cnt == '0);
    assign in_ready = (state != ST_DRAIN) && !flush_go;
    assign accept   = in_valid && in_ready;

    ibfj_core #(.NBITS(NBITS)) u_core (
        .a   (rd),
        .b   (in_data),
        .twd (twd),
        .up  (up),
        .down(down)
    );

    // Delay line is not reset; its contents are only read out while pending.
    always_ff @(posedge clk) begin
        if (accept) mem[cnt] <= (state == ST_BFLY) ? down : in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FILL;
            cnt       <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (flush_go) begin
                        state <= ST_DRAIN;
                    end else if (accept) begin
                        if (pending) begin
                            out_valid <= 1'b1;
                            out_data  <= rd;
                        end
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state   <= ST_BFLY;
                            pending <= 1'b0;
                        end
                    end
                end
                ST_BFLY: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_data  <= up;
                        cnt       <= cnt + 1'b1;
                        if (last) begin
                            state   <= ST_FILL;
                            pending <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    out_valid <= 1'b1;
                    out_data  <= rd;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        state   <= ST_FILL;
                        pending <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_ibfj_sdf_stage.sv
// Bench for ibfj_sdf_stage: directed spec vectors, flush, reset mid-block and
// randomized gap traffic scored against a sample-level butterfly model.
module tb_ibfj_sdf_stage;
    localparam int NB = 10;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*NB-1:0] in_data = '0;
    logic          twd = 1'b1;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [2*NB-1:0] out_data;

    ibfj_sdf_stage #(.NBITS(NB), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .twd(twd), .flush(flush),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2*NB-1:0] pk(input int r, input int i);
        logic [31:0] rr, ii;
        rr = r; ii = i;
        return {rr[NB-1:0], ii[NB-1:0]};
    endfunction

    function automatic int sre(input logic [2*NB-1:0] x);
        return int'($signed(x[2*NB-1:NB]));
    endfunction

    function automatic int sim(input logic [2*NB-1:0] x);
        return int'($signed(x[NB-1:0]));
    endfunction

    // Reference model: position within block, stored first half, queued downs.
    int              m_idx = 0;
    int              m_drain = 0;
    logic [2*NB-1:0] m_blk [D];
    logic [2*NB-1:0] m_downq [$];
    logic            exp_valid = 1'b0;
    logic [2*NB-1:0] exp_data = '0;
    logic [2*NB-1:0] log_q [$];

    function automatic logic m_ready(input logic f);
        return (m_drain == 0) && !(f && m_idx == 0 && m_downq.size() != 0);
    endfunction

    task automatic m_step(input logic v, input logic [2*NB-1:0] d, input logic t, input logic f);
        int ar, ai, br, bi;
        exp_valid = 1'b0;
        if (m_drain > 0) begin
            exp_valid = 1'b1;
            exp_data  = m_downq.pop_front();
            m_drain--;
        end else if (f && m_idx == 0 && m_downq.size() != 0) begin
            m_drain = D;
        end else if (v) begin
            if (m_idx < D) begin
                m_blk[m_idx] = d;
                if (m_downq.size() != 0) begin
                    exp_valid = 1'b1;
                    exp_data  = m_downq.pop_front();
                end
            end else begin
                ar = sre(m_blk[m_idx-D]); ai = sim(m_blk[m_idx-D]);
                br = sre(d); bi = sim(d);
                exp_valid = 1'b1;
                exp_data  = pk((ar + br) >>> 1, (ai + bi) >>> 1);
                if (t) m_downq.push_back(pk((ar - br) >>> 1, (ai - bi) >>> 1));
                else   m_downq.push_back(pk((bi - ai) >>> 1, (ar - br) >>> 1));
            end
            m_idx = (m_idx + 1) % (2 * D);
        end
    endtask

    task automatic m_clear();
        m_idx = 0; m_drain = 0; exp_valid = 1'b0; exp_data = '0;
        m_downq.delete();
    endtask

    task automatic cycle(input logic v, input logic [2*NB-1:0] d, input logic t, input logic f);
        logic rdy;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("out_data", 32'(out_data), 32'(exp_data));
        if (out_valid) log_q.push_back(out_data);
        in_valid = v; in_data = d; twd = t; flush = f;
        #1;
        rdy = m_ready(f);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        m_step(v && rdy, d, t, f);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        m_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2*NB-1:0] va [D];
    logic [2*NB-1:0] vb [D];

    initial begin
        va[0] = pk(100, 50);  vb[0] = pk(20, -10);
        va[1] = pk(-3, 0);    vb[1] = pk(0, 0);
        va[2] = pk(511, -512); vb[2] = pk(511, -512);
        va[3] = pk(7, -7);    vb[3] = pk(1, 1);

        #2;
        do_reset();

        // Directed: twd=1 block, twd=0 block, then flush with no input.
        for (int k = 0; k < D; k++) cycle(1'b1, va[k], 1'b1, 1'b0);
        for (int k = 0; k < D; k++) cycle(1'b1, vb[k], 1'b1, 1'b0);
        for (int k = 0; k < D; k++) cycle(1'b1, va[k], 1'b0, 1'b0);
        for (int k = 0; k < D; k++) cycle(1'b1, vb[k], 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < D + 2; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("log_size", 32'(log_q.size()), 32'(4 * D));
        if (log_q.size() >= 4 * D) begin
            chk("up0_t1",   32'(log_q[0]),  32'(pk(60, 20)));
            chk("up1_t1",   32'(log_q[1]),  32'(pk(-2, 0)));
            chk("up2_t1",   32'(log_q[2]),  32'(pk(511, -512)));
            chk("down0_t1", 32'(log_q[4]),  32'(pk(40, 30)));
            chk("down1_t1", 32'(log_q[5]),  32'(pk(-2, 0)));
            chk("down2_t1", 32'(log_q[6]),  32'(pk(0, 0)));
            chk("up0_t0",   32'(log_q[8]),  32'(pk(60, 20)));
            chk("down0_t0", 32'(log_q[12]), 32'(pk(-30, 40)));
        end

        // Flush with nothing pending must be ignored.
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-block after 6 of 8 samples; also leave downs pending first.
        for (int k = 0; k < 2 * D; k++) cycle(1'b1, pk(k * 3, -k), 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, pk(k * 11 - 40, k * 5), 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 2 * D; k++) cycle(1'b1, pk(k * 17 - 60, 9 - k), 1'b1, 1'b0);

        // Randomized traffic with gaps and occasional flush requests.
        for (int n = 0; n < 600; n++) begin
            logic v, t, f;
            logic [2*NB-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            t = 1'($urandom);
            f = ($urandom_range(0, 9) == 0);
            d = 2*NB'($urandom);
            cycle(v, d, t, f);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        while (m_idx != 0) cycle(1'b1, 2*NB'($urandom), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < D + 2; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("model_empty", 32'(m_downq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
